writeback_stage: RTL and testbench

Final stage of the RV32 pipeline, and the producer side of the decoder's register-file write port. It accepts one retiring instruction per cycle from the memory stage, waits for data-memory load returns, and selects the result. For loads it aligns and extends the data. It then emits a single-cycle register write (`wb_o_we`, `wb_o_addr_rd`, `wb_o_data_rd`), which drives the decoder stage's `ds_we` / `ds_data_in_rd` inputs and its rd address. It also back-pressures upstream stages while a load return is outstanding.

---
 rtl/writeback_stage_pkg.sv | 55 +++++
 rtl/writeback_stage_load_align.sv | 39 +++
 rtl/writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_writeback_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
//------------------------------------------------------------------------------
// Module : writeback_stage_pkg
// Brief  : Shared opcode width, one-hot opcode indices, load funct3 codes and
//          FSM state encoding for the writeback stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif

package writeback_stage_pkg;

    localparam int c_opcode_width = `OPCODE_WIDTH;

    localparam int c_op_load   = 0;
    localparam int c_op_store  = 1;
    localparam int c_op_branch = 2;
    localparam int c_op_jal    = 3;
    localparam int c_op_jalr   = 4;
    localparam int c_op_lui    = 5;
    localparam int c_op_auipc  = 6;
    localparam int c_op_rtype  = 7;
    localparam int c_op_itype  = 8;
    localparam int c_op_fence  = 9;
    localparam int c_op_system = 10;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_t;

    function automatic logic [c_opcode_width-1:0] opc_onehot(input int idx);
        logic [c_opcode_width-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Opcodes whose instructions produce a register result.
    localparam logic [c_opcode_width-1:0] c_rd_write_mask =
        c_opcode_width'((1 << c_op_load)  | (1 << c_op_jal)   | (1 << c_op_jalr) |
                        (1 << c_op_lui)   | (1 << c_op_auipc) | (1 << c_op_rtype) |
                        (1 << c_op_itype));

endpackage

`default_nettype wire

// File: rtl/writeback_stage_load_align.sv
//------------------------------------------------------------------------------
// Module : wb_load_align
// Brief  : Combinational load data alignment and sign/zero extension.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_load_align
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic [FUNCT_WIDTH-1:0] funct3,
    input  logic [1:0]             offset,
    input  logic [DWIDTH-1:0]      raw,
    output logic [DWIDTH-1:0]      data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = raw[{offset, 3'b000} +: 8];
        w_half = raw[{offset[1], 4'b0000} +: 16];
        data   = '0;
        case (funct3)
            c_f3_lb:  data = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            c_f3_lbu: data = {{(DWIDTH-8){1'b0}}, w_byte};
            c_f3_lh:  data = {{(DWIDTH-16){w_half[15]}}, w_half};
            c_f3_lhu: data = {{(DWIDTH-16){1'b0}}, w_half};
            c_f3_lw:  data = raw;
            default:  data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
//------------------------------------------------------------------------------
// Module : writeback_stage
// Brief  : RV32 writeback stage: load wait, result select, register write
//          pulse. Optional retired-instruction counter under WB_INSTRET_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif

module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int PC_WIDTH    = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic                     wb_i_ce,
    input  logic                     wb_i_stall,
    input  logic                     wb_i_flush,
    input  logic [`OPCODE_WIDTH-1:0] wb_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]   wb_i_funct3,
    input  logic [AWIDTH-1:0]        wb_i_addr_rd,
    input  logic [DWIDTH-1:0]        wb_i_alu_result,
    input  logic [PC_WIDTH-1:0]      wb_i_pc,
    input  logic [DWIDTH-1:0]        wb_i_load_data,
    input  logic                     wb_i_load_ack,
    output logic                     wb_o_we,
    output logic [AWIDTH-1:0]        wb_o_addr_rd,
    output logic [DWIDTH-1:0]        wb_o_data_rd,
    output logic                     wb_o_stall,
    output logic                     wb_o_flush
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]              wb_o_instret
`endif
);

    wb_state_t              r_state;
    logic [FUNCT_WIDTH-1:0] r_funct3;
    logic [AWIDTH-1:0]      r_rd;
    logic [1:0]             r_offset;
    logic                   r_we;
    logic [AWIDTH-1:0]      r_addr_rd;
    logic [DWIDTH-1:0]      r_data_rd;
    logic                   r_flush;

    logic                   w_waiting;
    logic                   w_accept;
    logic                   w_is_load;
    logic                   w_writes_rd;
    logic                   w_complete;
    logic                   w_wr_en;
    logic [AWIDTH-1:0]      w_wr_addr;
    logic [DWIDTH-1:0]      w_wr_data;
    logic [FUNCT_WIDTH-1:0] w_align_f3;
    logic [1:0]             w_align_off;
    logic [DWIDTH-1:0]      w_load_val;
    logic [PC_WIDTH-1:0]    w_pc_plus4;
    logic [DWIDTH-1:0]      w_result;

    assign w_waiting   = (r_state == ST_WAIT_LOAD);
    assign w_accept    = ~w_waiting & wb_i_ce & ~wb_i_stall & ~wb_i_flush;
    assign w_is_load   = wb_i_opcode[c_op_load];
    assign w_writes_rd = |(wb_i_opcode & c_rd_write_mask);

    // While waiting, alignment uses the latched load attributes.
    assign w_align_f3  = w_waiting ? r_funct3 : wb_i_funct3;
    assign w_align_off = w_waiting ? r_offset : wb_i_alu_result[1:0];

    wb_load_align #(
        .DWIDTH      (DWIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_load_align (
        .funct3 (w_align_f3),
        .offset (w_align_off),
        .raw    (wb_i_load_data),
        .data   (w_load_val)
    );

    assign w_pc_plus4 = wb_i_pc + PC_WIDTH'(4);

    always_comb begin
        w_result = wb_i_alu_result;
        if (w_is_load)
            w_result = w_load_val;
        else if (wb_i_opcode[c_op_jal] | wb_i_opcode[c_op_jalr])
            w_result = DWIDTH'(w_pc_plus4);
    end

    // Flush takes priority over a simultaneous load return.
    assign w_complete = w_waiting ? (wb_i_load_ack & ~wb_i_flush)
                                  : (w_accept & (~w_is_load | wb_i_load_ack));

    assign w_wr_en   = w_waiting ? (r_rd != '0) : (w_writes_rd & (wb_i_addr_rd != '0));
    assign w_wr_addr = w_waiting ? r_rd : wb_i_addr_rd;
    assign w_wr_data = w_waiting ? w_load_val : w_result;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state   <= ST_IDLE;
            r_funct3  <= '0;
            r_rd      <= '0;
            r_offset  <= '0;
            r_we      <= 1'b0;
            r_addr_rd <= '0;
            r_data_rd <= '0;
            r_flush   <= 1'b0;
        end else begin
            r_flush <= wb_i_flush;
            r_we    <= w_complete & w_wr_en;
            if (w_complete && w_wr_en) begin
                r_addr_rd <= w_wr_addr;
                r_data_rd <= w_wr_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_load && !wb_i_load_ack) begin
                        r_state  <= ST_WAIT_LOAD;
                        r_funct3 <= wb_i_funct3;
                        r_rd     <= wb_i_addr_rd;
                        r_offset <= wb_i_alu_result[1:0];
                    end
                end
                ST_WAIT_LOAD: begin
                    if (wb_i_flush || wb_i_load_ack)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_o_we      = r_we;
    assign wb_o_addr_rd = r_addr_rd;
    assign wb_o_data_rd = r_data_rd;
    assign wb_o_stall   = w_waiting;
    assign wb_o_flush   = r_flush;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst)
            r_instret <= '0;
        else if (w_complete)
            r_instret <= r_instret + 64'd1;
    end

    assign wb_o_instret = r_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
//------------------------------------------------------------------------------
// Module : tb_writeback_stage
// Brief  : Directed self-checking bench for writeback_stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic                      wb_clk;
    logic                      wb_rst;
    logic                      wb_i_ce;
    logic                      wb_i_stall;
    logic                      wb_i_flush;
    logic [c_opcode_width-1:0] wb_i_opcode;
    logic [2:0]                wb_i_funct3;
    logic [4:0]                wb_i_addr_rd;
    logic [31:0]               wb_i_alu_result;
    logic [31:0]               wb_i_pc;
    logic [31:0]               wb_i_load_data;
    logic                      wb_i_load_ack;
    logic                      wb_o_we;
    logic [4:0]                wb_o_addr_rd;
    logic [31:0]               wb_o_data_rd;
    logic                      wb_o_stall;
    logic                      wb_o_flush;
`ifdef WB_INSTRET_EN
    logic [63:0]               wb_o_instret;
`endif

    int errors = 0;
    int checks = 0;

    writeback_stage dut (
        .wb_clk          (wb_clk),
        .wb_rst          (wb_rst),
        .wb_i_ce         (wb_i_ce),
        .wb_i_stall      (wb_i_stall),
        .wb_i_flush      (wb_i_flush),
        .wb_i_opcode     (wb_i_opcode),
        .wb_i_funct3     (wb_i_funct3),
        .wb_i_addr_rd    (wb_i_addr_rd),
        .wb_i_alu_result (wb_i_alu_result),
        .wb_i_pc         (wb_i_pc),
        .wb_i_load_data  (wb_i_load_data),
        .wb_i_load_ack   (wb_i_load_ack),
        .wb_o_we         (wb_o_we),
        .wb_o_addr_rd    (wb_o_addr_rd),
        .wb_o_data_rd    (wb_o_data_rd),
        .wb_o_stall      (wb_o_stall),
        .wb_o_flush      (wb_o_flush)
`ifdef WB_INSTRET_EN
        ,
        .wb_o_instret    (wb_o_instret)
`endif
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic present(input int op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [31:0] ld, input logic ack);
        wb_i_ce         = 1'b1;
        wb_i_opcode     = opc_onehot(op);
        wb_i_funct3     = f3;
        wb_i_addr_rd    = rd;
        wb_i_alu_result = alu;
        wb_i_pc         = pc;
        wb_i_load_data  = ld;
        wb_i_load_ack   = ack;
    endtask

    task automatic idle_inputs();
        wb_i_ce       = 1'b0;
        wb_i_load_ack = 1'b0;
        wb_i_flush    = 1'b0;
        wb_i_stall    = 1'b0;
    endtask

    initial begin
        wb_rst          = 1'b0;
        wb_i_opcode     = '0;
        wb_i_funct3     = '0;
        wb_i_addr_rd    = '0;
        wb_i_alu_result = '0;
        wb_i_pc         = '0;
        wb_i_load_data  = '0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        chk("rst_stall", wb_o_stall, 0);
        chk("rst_we", wb_o_we, 0);
        chk("rst_addr", wb_o_addr_rd, 0);
        chk("rst_data", wb_o_data_rd, 0);
        chk("rst_flush", wb_o_flush, 0);
`ifdef WB_INSTRET_EN
        chk("rst_instret", wb_o_instret, 0);
`endif
        wb_rst = 1'b1;
        tick();

        // ITYPE write
        present(c_op_itype, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1'b0);
        tick();
        idle_inputs();
        chk("itype_we", wb_o_we, 1);
        chk("itype_addr", wb_o_addr_rd, 5);
        chk("itype_data", wb_o_data_rd, 32'h0000_1234);
        tick();
        chk("itype_we_single", wb_o_we, 0);
        chk("itype_data_hold", wb_o_data_rd, 32'h0000_1234);

        // Loads with same-cycle ack
        present(c_op_load, c_f3_lb, 5'd6, 32'h0000_0003, 32'h0, 32'h80FF_FF00, 1'b1);
        tick();
        chk("lb_we", wb_o_we, 1);
        chk("lb_data", wb_o_data_rd, 32'hFFFF_FF80);
        present(c_op_load, c_f3_lbu, 5'd7, 32'h0000_0003, 32'h0, 32'h80FF_FF00, 1'b1);
        tick();
        chk("lbu_addr", wb_o_addr_rd, 7);
        chk("lbu_data", wb_o_data_rd, 32'h0000_0080);
        present(c_op_load, c_f3_lh, 5'd7, 32'h0000_0002, 32'h0, 32'h80FF_FF00, 1'b1);
        tick();
        chk("lh_data", wb_o_data_rd, 32'hFFFF_80FF);
        present(c_op_load, c_f3_lhu, 5'd7, 32'h0000_0003, 32'h0, 32'h80FF_1234, 1'b1);
        tick();
        chk("lhu_data", wb_o_data_rd, 32'h0000_80FF);
        present(c_op_load, 3'b011, 5'd4, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk("f3_011_we", wb_o_we, 1);
        chk("f3_011_data", wb_o_data_rd, 0);

        // LW with ack delayed three cycles; other ce ignored meanwhile
        present(c_op_load, c_f3_lw, 5'd8, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
        tick();
        chk("lw_stall0", wb_o_stall, 1);
        chk("lw_we0", wb_o_we, 0);
        present(c_op_itype, 3'b000, 5'd9, 32'h0000_5555, 32'h0, 32'h0, 1'b0);
        tick();
        chk("lw_stall1", wb_o_stall, 1);
        chk("lw_we1", wb_o_we, 0);
        tick();
        chk("lw_stall2", wb_o_stall, 1);
        wb_i_ce        = 1'b0;
        wb_i_load_ack  = 1'b1;
        wb_i_load_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk("lw_stall_drop", wb_o_stall, 0);
        chk("lw_we", wb_o_we, 1);
        chk("lw_addr", wb_o_addr_rd, 8);
        chk("lw_data", wb_o_data_rd, 32'hDEAD_BEEF);
        tick();
        chk("lw_we_single", wb_o_we, 0);
        chk("lw_addr_hold", wb_o_addr_rd, 8);

        // Link, rd=0, store
        present(c_op_jal, 3'b000, 5'd1, 32'h0000_0999, 32'h0000_0100, 32'h0, 1'b0);
        tick();
        chk("jal_we", wb_o_we, 1);
        chk("jal_data", wb_o_data_rd, 32'h0000_0104);
        present(c_op_jalr, 3'b000, 5'd0, 32'h0000_0777, 32'h0000_0200, 32'h0, 1'b0);
        tick();
        chk("jalr_rd0_we", wb_o_we, 0);
        chk("jalr_rd0_hold", wb_o_data_rd, 32'h0000_0104);
        present(c_op_store, 3'b010, 5'd3, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
        tick();
        idle_inputs();
        chk("store_we", wb_o_we, 0);
`ifdef WB_INSTRET_EN
        // itype, lb, lbu, lh, lhu, f3_011, lw, jal, jalr, store
        chk("instret_count", wb_o_instret, 10);
`endif

        // Flush wins over simultaneous ack in WAIT_LOAD
        present(c_op_load, c_f3_lw, 5'd10, 32'h0000_0000, 32'h0, 32'h0, 1'b0);
        tick();
        chk("fl_stall", wb_o_stall, 1);
        wb_i_ce        = 1'b0;
        wb_i_flush     = 1'b1;
        wb_i_load_ack  = 1'b1;
        wb_i_load_data = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        chk("fl_we", wb_o_we, 0);
        chk("fl_stall_drop", wb_o_stall, 0);
        chk("fl_flush_out", wb_o_flush, 1);
`ifdef WB_INSTRET_EN
        chk("fl_instret", wb_o_instret, 10);
`endif
        tick();
        chk("fl_flush_clear", wb_o_flush, 0);
        chk("fl_no_late_we", wb_o_we, 0);

        // Stall in IDLE captures nothing; re-presented instruction retires once
        present(c_op_rtype, 3'b000, 5'd12, 32'h0000_ABCD, 32'h0, 32'h0, 1'b0);
        wb_i_stall = 1'b1;
        tick();
        chk("stall_no_we", wb_o_we, 0);
        wb_i_stall = 1'b0;
        tick();
        idle_inputs();
        chk("stall_retire_we", wb_o_we, 1);
        chk("stall_retire_data", wb_o_data_rd, 32'h0000_ABCD);
        tick();
        chk("stall_retire_once", wb_o_we, 0);

        // Async reset while waiting for a load
        present(c_op_load, c_f3_lw, 5'd11, 32'h0000_0000, 32'h0, 32'h0, 1'b0);
        tick();
        idle_inputs();
        chk("ar_stall", wb_o_stall, 1);
        #1 wb_rst = 1'b0;
        #1;
        chk("ar_stall_drop", wb_o_stall, 0);
        chk("ar_data_clear", wb_o_data_rd, 0);
        tick();
        wb_rst = 1'b1;
        wb_i_load_ack  = 1'b1;
        wb_i_load_data = 32'h1111_2222;
        tick();
        idle_inputs();
        chk("ar_dropped_we", wb_o_we, 0);
        chk("ar_addr", wb_o_addr_rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
